// File: rtl/l2_responder.sv
// rtl/l2_responder.sv - direct-mapped 64-line L2 responder with fixed hit/miss latency
module l2_responder #(
    parameter int HIT_LAT  = 2,
    parameter int MISS_LAT = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    input  logic [63:0]  req_addr,
    input  logic         req_we,
    input  logic [63:0]  req_wdata,
    input  logic [2:0]   req_wsize,
    input  logic         req_clf,
    output logic [127:0] data_out,
    output logic         resp_valid,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, RESP} state_t;

    localparam logic [3:0] HIT_CNT  = 4'(HIT_LAT);
    localparam logic [3:0] MISS_CNT = 4'(MISS_LAT);

    state_t       state_q, state_d;
    logic [3:0]   counter_q, counter_d;
    logic [63:0]  valid_q, valid_d;
    logic [127:0] data_out_q, data_out_d;
    logic         hit_q, hit_d;
    logic [3:0]   off_q, off_d;
    logic [5:0]   idx_q, idx_d;
    logic [23:0]  tag_q, tag_d;
    logic         we_q, we_d;
    logic         clf_q, clf_d;
    logic [63:0]  wdata_q, wdata_d;
    logic [1:0]   size_q, size_d;

    logic [127:0] data_mem [64];
    logic [23:0]  tag_mem  [64];
    logic         mem_we;
    logic [127:0] mem_wdata;
    logic [127:0] merged;
    logic [3:0]   nbytes;
    logic [4:0]   pos;

    logic unused_addr;
    assign unused_addr = ^req_addr[63:34];

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        valid_d    = valid_q;
        data_out_d = data_out_q;
        hit_d      = hit_q;
        off_d      = off_q;
        idx_d      = idx_q;
        tag_d      = tag_q;
        we_d       = we_q;
        clf_d      = clf_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        merged     = '0;
        nbytes     = 4'd1 << size_q;
        pos        = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_d   = req_addr[3:0];
                    idx_d   = req_addr[9:4];
                    tag_d   = req_addr[33:10];
                    we_d    = req_we;
                    clf_d   = req_clf;
                    wdata_d = req_wdata;
                    size_d  = (req_wsize > 3'd3) ? 2'd3 : req_wsize[1:0];
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d     = valid_q[idx_q] && (tag_mem[idx_q] == tag_q);
                counter_d = hit_d ? HIT_CNT : MISS_CNT;
                state_d   = WAIT;
            end
            WAIT: begin
                counter_d = counter_q - 4'd1;
                if (counter_d == 4'd0) begin
                    state_d = RESP;
                    if (clf_q) begin
                        // Flush only invalidates; stale data stays behind the cleared valid bit.
                        if (hit_q) begin
                            valid_d[idx_q] = 1'b0;
                        end
                        data_out_d = '0;
                    end else begin
                        merged = hit_q ? data_mem[idx_q] : '0;
                        if (we_q) begin
                            for (int i = 0; i < 8; i++) begin
                                pos = {1'b0, off_q} + 5'(i);
                                if ((4'(i) < nbytes) && !pos[4]) begin
                                    merged[{pos[3:0], 3'b000} +: 8] = wdata_q[i*8 +: 8];
                                end
                            end
                        end
                        mem_we         = 1'b1;
                        mem_wdata      = merged;
                        valid_d[idx_q] = 1'b1;
                        data_out_d     = merged;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            valid_q    <= '0;
            data_out_q <= '0;
            hit_q      <= 1'b0;
            off_q      <= '0;
            idx_q      <= '0;
            tag_q      <= '0;
            we_q       <= 1'b0;
            clf_q      <= 1'b0;
            wdata_q    <= '0;
            size_q     <= '0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
            hit_q      <= hit_d;
            off_q      <= off_d;
            idx_q      <= idx_d;
            tag_q      <= tag_d;
            we_q       <= we_d;
            clf_q      <= clf_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
        end
    end

    // Arrays are not reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            data_mem[idx_q] <= mem_wdata;
            tag_mem[idx_q]  <= tag_q;
        end
    end

    assign data_out   = data_out_q;
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_l2_responder.sv
// tb/tb_l2_responder.sv - randomized self-checking bench for l2_responder
module tb_l2_responder;

    localparam int HIT_LAT  = 2;
    localparam int MISS_LAT = 6;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic [63:0]  req_addr;
    logic         req_we;
    logic [63:0]  req_wdata;
    logic [2:0]   req_wsize;
    logic         req_clf;
    logic [127:0] data_out;
    logic         resp_valid;
    logic         busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    bit          m_valid [64];
    logic [23:0] m_tag   [64];
    logic [7:0]  m_data  [64][16];

    l2_responder #(.HIT_LAT(HIT_LAT), .MISS_LAT(MISS_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .req_wsize  (req_wsize),
        .req_clf    (req_clf),
        .data_out   (data_out),
        .resp_valid (resp_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected latency is counted in rising edges after the accepting edge until resp_valid is seen.
    task automatic model_op(input logic we, input logic clf, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [2:0] wsize,
                            output int exp_lat, output logic [127:0] exp_dout);
        int idx;
        int off;
        int nbytes;
        bit hit;
        idx = int'(addr[9:4]);
        off = int'(addr[3:0]);
        hit = m_valid[idx] && (m_tag[idx] == addr[33:10]);
        exp_lat = (hit ? HIT_LAT : MISS_LAT) + 1;
        exp_dout = '0;
        if (clf) begin
            if (hit) m_valid[idx] = 1'b0;
        end else begin
            if (!hit) begin
                m_valid[idx] = 1'b1;
                m_tag[idx] = addr[33:10];
                for (int b = 0; b < 16; b++) m_data[idx][b] = 8'h00;
            end
            if (we) begin
                nbytes = 1 << ((wsize > 3) ? 3 : int'(wsize));
                for (int i = 0; i < nbytes; i++)
                    if (off + i < 16) m_data[idx][off + i] = wdata[i*8 +: 8];
            end
            for (int b = 0; b < 16; b++) exp_dout[b*8 +: 8] = m_data[idx][b];
        end
    endtask

    task automatic issue(input logic we, input logic clf, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [2:0] wsize,
                         output int lat, output logic [127:0] dout);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_clf = clf;
        req_addr = addr; req_wdata = wdata; req_wsize = wsize;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!resp_valid) lat = -1;
        dout = data_out;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
        req_wdata = '0; req_wsize = '0; req_clf = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++;
        if (resp_valid !== 1'b0) $display("FAIL reset_resp: got %b expected 0", resp_valid); else pass_cnt++;
        total_cnt++;
        if (data_out !== 128'h0) $display("FAIL reset_data: got %h expected 0", data_out); else pass_cnt++;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cold_read_and_write();
        int lat, elat;
        logic [127:0] d, ed;
        do_reset();
        model_op(0, 0, 64'h40, 64'h0, 3'd0, elat, ed);
        issue(0, 0, 64'h40, 64'h0, 3'd0, lat, d);
        total_cnt++;
        if (lat !== elat) $display("FAIL cold_lat: got %0d expected %0d", lat, elat); else pass_cnt++;
        total_cnt++;
        if (d !== ed) $display("FAIL cold_data: got %h expected %h", d, ed); else pass_cnt++;
        model_op(0, 0, 64'h40, 64'h0, 3'd0, elat, ed);
        issue(0, 0, 64'h40, 64'h0, 3'd0, lat, d);
        total_cnt++;
        if (lat !== elat) $display("FAIL cold_line_valid_lat: got %0d expected %0d", lat, elat); else pass_cnt++;

        do_reset();
        model_op(1, 0, 64'h43, 64'hDEADBEEF, 3'd2, elat, ed);
        issue(1, 0, 64'h43, 64'hDEADBEEF, 3'd2, lat, d);
        total_cnt++;
        if (lat !== elat) $display("FAIL wr_lat: got %0d expected %0d", lat, elat); else pass_cnt++;
        model_op(0, 0, 64'h40, 64'h0, 3'd0, elat, ed);
        issue(0, 0, 64'h40, 64'h0, 3'd0, lat, d);
        total_cnt++;
        if (lat !== elat) $display("FAIL rd_hit_lat: got %0d expected %0d", lat, elat); else pass_cnt++;
        total_cnt++;
        if (d !== (128'hDEADBEEF << 24)) $display("FAIL rd_hit_data: got %h expected %h", d, 128'hDEADBEEF << 24); else pass_cnt++;
    endtask

    task automatic test_boundary_and_clf();
        int lat, elat;
        logic [127:0] d, ed;
        do_reset();
        model_op(1, 0, 64'h4E, 64'h1122334455667788, 3'd3, elat, ed);
        issue(1, 0, 64'h4E, 64'h1122334455667788, 3'd3, lat, d);
        total_cnt++;
        if (d !== {16'h7788, 112'h0}) $display("FAIL boundary_data: got %h expected %h", d, {16'h7788, 112'h0}); else pass_cnt++;
        total_cnt++;
        if (d !== ed) $display("FAIL boundary_model: got %h expected %h", d, ed); else pass_cnt++;

        model_op(0, 0, 64'h440, 64'h0, 3'd0, elat, ed);
        issue(0, 0, 64'h440, 64'h0, 3'd0, lat, d);
        total_cnt++;
        if (lat !== elat || d !== ed) $display("FAIL conflict_read: got lat %0d data %h expected lat %0d data %h", lat, d, elat, ed); else pass_cnt++;
        model_op(0, 1, 64'h40, 64'h0, 3'd0, elat, ed);
        issue(0, 1, 64'h40, 64'h0, 3'd0, lat, d);
        total_cnt++;
        if (lat !== elat || d !== 128'h0) $display("FAIL clf_nomatch: got lat %0d data %h expected lat %0d data 0", lat, d, elat); else pass_cnt++;
        model_op(0, 1, 64'h440, 64'h0, 3'd0, elat, ed);
        issue(0, 1, 64'h440, 64'h0, 3'd0, lat, d);
        total_cnt++;
        if (lat !== elat || d !== 128'h0) $display("FAIL clf_match: got lat %0d data %h expected lat %0d data 0", lat, d, elat); else pass_cnt++;
        model_op(0, 0, 64'h440, 64'h0, 3'd0, elat, ed);
        issue(0, 0, 64'h440, 64'h0, 3'd0, lat, d);
        total_cnt++;
        if (lat !== elat) $display("FAIL clf_invalidated_lat: got %0d expected %0d", lat, elat); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int lat, elat, pulses, first;
        logic [127:0] d, ed, cap;
        do_reset();
        model_op(0, 0, 64'h1230, 64'h0, 3'd0, elat, ed);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_clf = 1'b0; req_addr = 64'h1230;
        @(posedge clk);
        @(negedge clk);
        pulses = 0; first = -1; cap = '0;
        for (int c = 0; c < 20; c++) begin
            if (resp_valid === 1'b1) begin
                pulses++;
                if (first < 0) begin first = c; cap = data_out; end
            end
            req_valid = (c < 5);
            req_we = 1'b1; req_clf = 1'b0;
            req_addr = 64'h1230; req_wdata = {$urandom, $urandom} | 64'h1; req_wsize = 3'd3;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        total_cnt++;
        if (pulses !== 1) $display("FAIL busy_pulses: got %0d expected 1", pulses); else pass_cnt++;
        total_cnt++;
        if (first !== elat || cap !== ed) $display("FAIL busy_resp: got lat %0d data %h expected lat %0d data %h", first, cap, elat, ed); else pass_cnt++;
        model_op(0, 0, 64'h1230, 64'h0, 3'd0, elat, ed);
        issue(0, 0, 64'h1230, 64'h0, 3'd0, lat, d);
        total_cnt++;
        if (lat !== elat || d !== ed) $display("FAIL busy_no_write: got lat %0d data %h expected lat %0d data %h", lat, d, elat, ed); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int lat, elat, pulses;
        logic [127:0] d, ed;
        do_reset();
        model_op(1, 0, 64'h90, 64'hCAFEF00D12345678, 3'd3, elat, ed);
        issue(1, 0, 64'h90, 64'hCAFEF00D12345678, 3'd3, lat, d);
        total_cnt++;
        if (d !== ed) $display("FAIL abort_prewrite: got %h expected %h", d, ed); else pass_cnt++;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_clf = 1'b0;
        req_addr = 64'h80; req_wdata = 64'hA5A5A5A5A5A5A5A5; req_wsize = 3'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || data_out !== 128'h0) $display("FAIL abort_async: got busy %b data %h expected busy 0 data 0", busy, data_out); else pass_cnt++;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) pulses++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL abort_resp: got %0d pulses expected 0", pulses); else pass_cnt++;
        model_op(0, 0, 64'h80, 64'h0, 3'd0, elat, ed);
        issue(0, 0, 64'h80, 64'h0, 3'd0, lat, d);
        total_cnt++;
        if (lat !== elat || d !== 128'h0) $display("FAIL abort_reread: got lat %0d data %h expected lat %0d data 0", lat, d, elat); else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, elat, op, errs;
        logic [127:0] d, ed;
        logic [63:0] a, wd;
        logic [2:0] ws;
        logic we, clf;
        do_reset();
        errs = 0;
        for (int n = 0; n < 200; n++) begin
            a = {$urandom, $urandom};
            a[9:4] = 6'($urandom_range(0, 3));
            a[33:10] = 24'($urandom_range(0, 2));
            wd = {$urandom, $urandom};
            ws = 3'($urandom_range(0, 7));
            op = $urandom_range(0, 99);
            clf = (op < 15);
            we = (op >= 15 && op < 60);
            model_op(we, clf, a, wd, ws, elat, ed);
            issue(we, clf, a, wd, ws, lat, d);
            total_cnt++;
            if (lat !== elat || d !== ed) begin
                $display("FAIL rand_op%0d: got lat %0d data %h expected lat %0d data %h", n, lat, d, elat, ed);
                errs++;
            end else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rand_single_pulse%0d: got resp %b busy %b expected 0 0", n, resp_valid, busy); else pass_cnt++;
            if (errs > 5) break;
        end
    endtask

    initial begin
        test_reset();
        test_cold_read_and_write();
        test_boundary_and_clf();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
